// File: rtl/multi_ctrl_if.sv
// Request/response handshake bundle between execute stage and multiply controller.
interface multi_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_is_w;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;

    // Execute-stage side: issues requests, consumes results
    modport master (
        output in_valid, in_op, in_is_w, in_src1, in_src2, out_ready,
        input  in_ready, out_valid, out_result
    );

    // Controller side
    modport slave (
        input  in_valid, in_op, in_is_w, in_src1, in_src2, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/multi_ctrl.sv
// Sequencer for the two-stage 64-bit multiplier: accepts one RV64M multiply,
// steers the datapath controls, holds the product and returns it.
module multi_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    multi_ctrl_if.slave       bus,
    input  logic              flush,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count,
    output logic [63:0]       mul_src1,
    output logic [63:0]       mul_src2,
    output logic [1:0]        mul_ctr_in,
    output logic [1:0]        mul_ctr,
    output logic              mul_is_w,
    output logic              mul_block,
    input  logic [63:0]       mul_result
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned OP_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [OP_W-1:0]   r_op;
    logic              r_w;
    logic [XLEN-1:0]   r_res;
    logic [CNT_W-1:0]  r_count;
    logic              w_in_ready;
    logic              w_acc;
    logic              w_cnt_inc;
    logic              w_res_ld;

    // Handshake decode: ready depends only on state, out_ready and flush
    always_comb begin
        w_in_ready = ~flush & ((r_state == IDLE) | ((r_state == DONE) & bus.out_ready));
        w_acc      = bus.in_valid & w_in_ready & ~flush;
    end

    // Next-state and control strobes; flush overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_inc   = 1'b0;
        w_res_ld    = 1'b0;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_acc) w_state_nxt = S1;
                S1:   w_state_nxt = S2;
                S2: begin
                    w_res_ld    = 1'b1;
                    w_state_nxt = DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        w_cnt_inc   = 1'b1;
                        w_state_nxt = w_acc ? S1 : IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Opcode and word-form capture on accept; word form only meaningful for mul
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= '0;
            r_w  <= 1'b0;
        end else if (w_acc) begin
            r_op <= bus.in_op;
            r_w  <= bus.in_is_w & (bus.in_op == 2'b00);
        end
    end

    // Result holding register, loaded when the multiplier's product is valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_res <= '0;
        else if (w_res_ld) r_res <= mul_result;
    end

    // Completed-operation counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_count <= '0;
        else if (w_cnt_inc) r_count <= r_count + CNT_W'(1);
    end

    // Output and datapath drive
    always_comb begin
        bus.in_ready   = w_in_ready;
        bus.out_valid  = (r_state == DONE);
        bus.out_result = r_res;
        busy           = (r_state != IDLE);
        op_count       = r_count;
        mul_src1       = bus.in_src1;
        mul_src2       = bus.in_src2;
        mul_ctr_in     = bus.in_op;
        mul_ctr        = r_op;
        mul_is_w       = r_w;
        mul_block      = ~w_acc;
    end

endmodule

// File: tb/tb_multi_ctrl.sv
// Self-checking bench for multi_ctrl with a behavioural two-stage multiplier.
module tb_multi_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        busy;
    logic [31:0] op_count;
    logic [63:0] mul_src1, mul_src2, mul_result;
    logic [1:0]  mul_ctr_in, mul_ctr;
    logic        mul_is_w, mul_block;

    multi_ctrl_if bus();

    multi_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush      (flush),
        .busy       (busy),
        .op_count   (op_count),
        .mul_src1   (mul_src1),
        .mul_src2   (mul_src2),
        .mul_ctr_in (mul_ctr_in),
        .mul_ctr    (mul_ctr),
        .mul_is_w   (mul_is_w),
        .mul_block  (mul_block),
        .mul_result (mul_result)
    );

    always #5 clk = ~clk;

    // Multiplier model: operands on first edge, product selected on second
    logic [63:0]  m_a, m_b;
    logic [1:0]   m_ctr_in_q;
    logic [127:0] m_full;
    logic [63:0]  m_p;

    always @(posedge clk) begin
        if (!mul_block) begin
            m_a        <= mul_src1;
            m_b        <= mul_src2;
            m_ctr_in_q <= mul_ctr_in;
        end
    end

    always_comb begin
        case (mul_ctr)
            2'b01:   m_full = {{64{m_a[63]}}, m_a} * {{64{m_b[63]}}, m_b};
            2'b10:   m_full = {{64{m_a[63]}}, m_a} * {64'd0, m_b};
            default: m_full = {64'd0, m_a} * {64'd0, m_b};
        endcase
    end

    always @(posedge clk) begin
        if (mul_ctr == 2'b00)
            m_p <= mul_is_w ? {{32{m_full[31]}}, m_full[31:0]} : m_full[63:0];
        else
            m_p <= m_full[127:64];
    end
    assign mul_result = m_p;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[9];

    // Single op from IDLE: check latency, result, control and count
    task automatic do_op(input vec_t v);
        int cyc;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = v.op; bus.in_is_w = v.w;
        bus.in_src1 = v.a; bus.in_src2 = v.b; bus.out_ready = 1'b0;
        chk({v.name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk({v.name, "_latency"}, 64'(cyc), 64'd3);
        chk({v.name, "_result"}, bus.out_result, v.exp);
        chk({v.name, "_ctr"}, 64'(mul_ctr), 64'(v.op));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        exp_cnt++;
        chk({v.name, "_count"}, 64'(op_count), 64'(exp_cnt));
        chk({v.name, "_drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{"mul_3x5",     2'b00, 1'b0, 64'd3, 64'd5, 64'h000000000000000F};
        vecs[1] = '{"mulw_max",    2'b00, 1'b1, 64'h7FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE};
        vecs[2] = '{"mulh_m1m1",   2'b01, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0};
        vecs[3] = '{"mulhu_max",   2'b11, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE};
        vecs[4] = '{"mulhsu_m1x2", 2'b10, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFF};
        vecs[5] = '{"mulh_w_ign",  2'b01, 1'b1, 64'h4000000000000000, 64'd4, 64'h1};
        vecs[6] = '{"mul_32sq",    2'b00, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[7] = '{"mulw_32sq",   2'b00, 1'b1, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h1};
        vecs[8] = '{"mulhu_w_ign", 2'b11, 1'b1, 64'h8000000000000000, 64'd2, 64'h1};

        rst_n = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_is_w = 1'b0;
        bus.in_src1 = '0; bus.in_src2 = '0; bus.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_result", bus.out_result, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_count", 64'(op_count), 64'd0);
        chk("rst_mul_ctr", 64'(mul_ctr), 64'd0);
        chk("rst_mul_is_w", 64'(mul_is_w), 64'd0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);

        for (int i = 0; i < 9; i++) do_op(vecs[i]);

        // Backpressure: result stable, no acceptance, operand changes ignored
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_is_w = 1'b0;
        bus.in_src1 = 64'd3; bus.in_src2 = 64'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_cycles(3);
        chk("bp_valid", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b1; bus.in_src1 = 64'd100;
        for (int i = 0; i < 5; i++) begin
            chk("bp_stable", bus.out_result, 64'h000000000000000F);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
            bus.in_src1 = 64'(i + 200);
        end
        chk("bp_still_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_count_hold", 64'(op_count), 64'(exp_cnt));
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        exp_cnt++;
        chk("bp_count", 64'(op_count), 64'(exp_cnt));
        chk("bp_idle", 64'(busy), 64'd0);

        // Back-to-back with out_ready tied high
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_is_w = 1'b0;
        bus.in_src1 = 64'd2; bus.in_src2 = 64'd3;
        @(posedge clk); #1;
        bus.in_src1 = 64'd4; bus.in_src2 = 64'd5;
        wait_cycles(3);
        chk("b2b_first_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b_first_result", bus.out_result, 64'd6);
        chk("b2b_ready_in_done", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_cnt++;
        wait_cycles(1);
        chk("b2b_second_busy", 64'(busy), 64'd1);
        chk("b2b_gap", 64'(bus.out_valid), 64'd0);
        wait_cycles(2);
        chk("b2b_second_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b_second_result", bus.out_result, 64'd20);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        exp_cnt++;
        chk("b2b_count", 64'(op_count), 64'(exp_cnt));

        // Flush in S2
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_src1 = 64'd7; bus.in_src2 = 64'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_cycles(2);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_s2_busy", 64'(busy), 64'd0);
        wait_cycles(3);
        chk("fl_s2_no_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_s2_count", 64'(op_count), 64'(exp_cnt));

        // Flush in DONE with out_ready high: no count
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_cycles(3);
        chk("fl_done_valid", 64'(bus.out_valid), 64'd1);
        flush = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; bus.out_ready = 1'b0;
        chk("fl_done_drop", 64'(bus.out_valid), 64'd0);
        chk("fl_done_count", 64'(op_count), 64'(exp_cnt));

        // Flush with request in IDLE: not accepted
        @(negedge clk);
        flush = 1'b1; bus.in_valid = 1'b1;
        #1;
        chk("fl_idle_ready", 64'(bus.in_ready), 64'd0);
        chk("fl_idle_block", 64'(mul_block), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("fl_idle_busy", 64'(busy), 64'd0);

        // Reset mid-operation
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_src1 = 64'd9; bus.in_src2 = 64'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("mr_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_count", 64'(op_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (bus.out_valid) seen = 1'b1;
            end
            chk("mr_no_output", 64'(seen), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/multi_ctrl.md
# multi_ctrl

Sequencing controller for the two-stage 64-bit multiplier datapath (operands registered on the first edge, product selected and registered on the second). It accepts one RV64M multiply request at a time from the execute stage over a valid/ready handshake. It drives the multiplier's operand, opcode and hold controls at the correct cycles, captures the result into its own holding register, and returns it over a second valid/ready handshake. It also supports pipeline flush and counts completed operations.

## Interface
Parameters:
- CNT_W, 32, width of the completed-operation counter

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  request present
- in_ready  out  1  controller can accept a request
- in_op  in  2  00 mul, 01 mulh, 10 mulhsu, 11 mulhu
- in_is_w  in  1  32-bit word form (meaningful only with in_op=00)
- in_src1  in  64  operand 1
- in_src2  in  64  operand 2
- flush  in  1  kill any in-flight or pending operation
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  64  result
- busy  out  1  state != IDLE
- op_count  out  CNT_W  completed-operation counter
- mul_src1  out  64  to multiplier src1_in
- mul_src2  out  64  to multiplier src2_in
- mul_ctr_in  out  2  to multiplier ALUctr_in
- mul_ctr  out  2  to multiplier ALUctr
- mul_is_w  out  1  to multiplier is_w
- mul_block  out  1  to multiplier block (1 = hold operand registers)
- mul_result  in  64  from multiplier result

## Operation
- States: IDLE, S1 (operands latched in multiplier), S2 (product latched in multiplier), DONE (result held).
- Accept: acc = in_valid & in_ready & ~flush. in_ready = ~flush & (state==IDLE | (state==DONE & out_ready)).
- mul_src1/mul_src2/mul_ctr_in: combinational pass-through of in_src1/in_src2/in_op. mul_block = ~acc, so multiplier operand registers load only on accept.
- On acc: store op_q=in_op and w_q=in_is_w&(in_op==00). in_is_w with op≠00 is ignored. Go to S1.
- S1: mul_ctr=op_q, mul_is_w=w_q. Go to S2. In all other states, mul_ctr=op_q and mul_is_w=w_q (don't-care to the datapath).
- S2: res_q <= mul_result. Go to DONE.
- DONE: out_valid=1, out_result=res_q. On out_ready: op_count += 1 (wraps modulo 2^CNT_W). Then go to S1 if acc in the same cycle, else IDLE. Without out_ready: stay in DONE; res_q and out_result stay stable.
- flush (synchronous, highest priority): state->IDLE and out_valid drops next cycle. No count increment, even if out_ready is high in the same cycle. res_q is retained but invisible. No acceptance that cycle.
- Result semantics: mul = low 64 bits. mulw = sign-extended low 32 bits. mulh/mulhsu/mulhu = high 64 bits, signed×signed / signed×unsigned / unsigned×unsigned.

## Timing
- Reset (rst_n low, async): state=IDLE, res_q=0, op_q=0, w_q=0, op_count=0. Resulting outputs: out_valid=0, out_result=0, busy=0, in_ready=1 (if flush=0), mul_ctr=0, mul_is_w=0.
- Latency: accept on edge E0; out_valid high in the cycle after E2 (3 edges).
- Back-to-back throughput: one op per 3 cycles. DONE with out_ready and a new acc goes straight to S1.
- out_valid is registered state; no combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready and flush only.
- rst_n deasserted mid-operation: the operation is lost and no output appears.

## Test plan
- Reset: rst_n low mid-S1 -> out_valid=0, busy=0, op_count=0 immediately; after release in_ready=1.
- Basic: mul 3×5 accepted at edge 0 -> out_valid at cycle 3 with 0x000000000000000F. op_count goes 0->1 on handshake.
- Ops: mulw 0x7FFFFFFF×2 -> 0xFFFFFFFFFFFFFFFE; mulh -1×-1 -> 0; mulhu 0xFFFF_FFFF_FFFF_FFFF×0xFFFF_FFFF_FFFF_FFFF -> 0xFFFFFFFFFFFFFFFE; mulhsu -1×2 -> 0xFFFFFFFFFFFFFFFF; mulh with in_is_w=1, 2^62×4 -> 1 (is_w ignored).
- Backpressure: out_ready low 5 cycles in DONE -> out_result stable and in_ready=0. Change in_src1 during the wait -> result unchanged.
- Back-to-back: two valid requests with out_ready tied high -> second accepted on the same edge the first is consumed; results 3 cycles apart; op_count=2.
- Flush: flush in S2 -> IDLE next cycle, no out_valid, op_count unchanged. flush with in_valid in IDLE -> in_ready=0, not accepted.
